// File: rtl/branch_predictor_table.sv
// Pattern history table of 2-bit saturating counters with registered lookup,
// same-cycle update bypass and a saturating misprediction counter.
module branch_predictor_table #(
   parameter int unsigned ADDR_W_BITS = 3,
   parameter int unsigned CNT_BITS    = 8,
   parameter logic [1:0]  INIT_STATE  = 2'b01
) (
   input  logic                   CLOCK,
   input  logic                   INIT,
   input  logic                   LOOKUP_EN,
   input  logic [ADDR_W_BITS-1:0] ADDR,
   input  logic                   UPDATE_EN,
   input  logic [ADDR_W_BITS-1:0] ADDR_W,
   input  logic                   OUTCOME,
   input  logic                   MISS,
   output logic                   PREDICTION,
   output logic                   PRED_VALID,
   output logic [1:0]             PRED_STATE,
   output logic [CNT_BITS-1:0]    MISS_COUNT
);

   localparam int unsigned DEPTH = 2 ** ADDR_W_BITS;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam logic [CNT_BITS-1:0] MISS_MAX = {CNT_BITS{1'b1}};

   logic [1:0] entry_q [DEPTH];
   logic [1:0] upd_cur;
   logic [1:0] upd_state;
   logic [1:0] lkp_state;

   assign upd_cur = entry_q[ADDR_W];

   always_comb begin
      upd_state = upd_cur;
      case (upd_cur)
         SNT:     upd_state = OUTCOME ? WNT : SNT;
         WNT:     upd_state = OUTCOME ? WT  : SNT;
         WT:      upd_state = OUTCOME ? ST  : WNT;
         ST:      upd_state = OUTCOME ? ST  : WT;
         default: upd_state = upd_cur;
      endcase
   end

   // Same-index update in the lookup cycle forwards the post-update value.
   always_comb begin
      lkp_state = entry_q[ADDR];
      if (UPDATE_EN && (ADDR == ADDR_W)) begin
         lkp_state = upd_state;
      end
   end

   always_ff @(posedge CLOCK or posedge INIT) begin
      if (INIT) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= INIT_STATE;
         end
      end else if (UPDATE_EN) begin
         entry_q[ADDR_W] <= upd_state;
      end
   end

   always_ff @(posedge CLOCK or posedge INIT) begin
      if (INIT) begin
         PREDICTION <= 1'b0;
         PRED_VALID <= 1'b0;
         PRED_STATE <= INIT_STATE;
      end else begin
         PRED_VALID <= LOOKUP_EN;
         if (LOOKUP_EN) begin
            PRED_STATE <= lkp_state;
            PREDICTION <= lkp_state[1];
         end
      end
   end

   always_ff @(posedge CLOCK or posedge INIT) begin
      if (INIT) begin
         MISS_COUNT <= '0;
      end else if (UPDATE_EN && MISS && (MISS_COUNT != MISS_MAX)) begin
         MISS_COUNT <= MISS_COUNT + CNT_BITS'(1);
      end
   end

endmodule
